selecionar_ativo: RTL and testbench

- Consumer end of the active-node criterion interface: takes the global criterion produced by the active-node classifier, scans the active-node slots and grants exactly one node whose criterion equals it.
- Sits between the active-node classifier and the node-expansion logic; returns the granted node's address and criterion with a valid/ack handshake.
- Round-robin start pointer gives fairness among equal-criterion nodes.

---
 rtl/selecionar_ativo_pkg.sv | 29 ++
 rtl/selecionar_ativo_if.sv | 29 ++
 rtl/selecionar_ativo_rr_idx.sv | 38 +++
 rtl/selecionar_ativo.sv | 199 +++++++++++++++++++
 tb/tb_selecionar_ativo.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/selecionar_ativo_pkg.sv
// rtl/selecionar_ativo_pkg.sv - shared FSM encodings, default widths and slot slice helper
package selecionar_ativo_pkg;

  localparam int NUM_NA_DEF         = 8;
  localparam int ADR_WIDTH_DEF      = 8;
  localparam int CRITERIO_WIDTH_DEF = 5;

  // Helper operates on a generously sized bus; callers zero-extend in and truncate out.
  localparam int BUS_MAX_W  = 1024;
  localparam int SLOT_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN     = 2'd1,
    ST_GRANT    = 2'd2,
    ST_MIN_SCAN = 2'd3
  } sa_state_e;

  function automatic logic [SLOT_MAX_W-1:0] slot_slice(
    input logic [BUS_MAX_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          width
  );
    logic [SLOT_MAX_W-1:0] mask;
    mask = (SLOT_MAX_W'(1) << width) - SLOT_MAX_W'(1);
    return SLOT_MAX_W'(bus >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/selecionar_ativo_if.sv
// rtl/selecionar_ativo_if.sv - request/slot/grant bundle between classifier, selector and expander
interface selecionar_ativo_if #(
  parameter int NUM_NA         = 8,
  parameter int ADR_WIDTH      = 8,
  parameter int CRITERIO_WIDTH = 5
);
  logic                             start_in;
  logic [NUM_NA-1:0]                na_valid_in;
  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in;
  logic [NUM_NA*ADR_WIDTH-1:0]      na_endereco_in;
  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in;
  logic                             ack_in;
  logic                             sa_valid_out;
  logic [NUM_NA-1:0]                sa_grant_out;
  logic [ADR_WIDTH-1:0]             sa_endereco_out;
  logic [CRITERIO_WIDTH-1:0]        sa_criterio_out;
  logic                             sa_busy_out;
  logic                             sa_vazio_out;

  modport master (
    output start_in, na_valid_in, na_criterio_in, na_endereco_in, ca_criterio_geral_in, ack_in,
    input  sa_valid_out, sa_grant_out, sa_endereco_out, sa_criterio_out, sa_busy_out, sa_vazio_out
  );

  modport slave (
    input  start_in, na_valid_in, na_criterio_in, na_endereco_in, ca_criterio_geral_in, ack_in,
    output sa_valid_out, sa_grant_out, sa_endereco_out, sa_criterio_out, sa_busy_out, sa_vazio_out
  );
endinterface

// File: rtl/selecionar_ativo_rr_idx.sv
// rtl/selecionar_ativo_rr_idx.sv - round-robin start pointer and modulo-NUM_NA scan index
module selecionar_ativo_rr_idx #(
  parameter int NUM_NA = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      inc,
  input  logic                      ptr_adv,
  output logic [$clog2(NUM_NA)-1:0] idx,
  output logic [$clog2(NUM_NA)-1:0] ptr
);
  localparam int IDX_W = $clog2(NUM_NA);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NA - 1);

  // Explicit compare so non-power-of-two slot counts wrap correctly.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == LAST) ? '0 : x + IDX_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      ptr <= '0;
    end else begin
      if (load) begin
        idx <= ptr;
      end else if (inc) begin
        idx <= wrap_inc(idx);
      end
      // idx still holds the granted slot while in GRANT
      if (ptr_adv) begin
        ptr <= wrap_inc(idx);
      end
    end
  end

endmodule

// File: rtl/selecionar_ativo.sv
// rtl/selecionar_ativo.sv - grants one active node whose criterion equals the reference criterion
// Optional SELECIONAR_ATIVO_MIN_INTERNO_EN: reference is the internal minimum over valid slots.
module selecionar_ativo
  import selecionar_ativo_pkg::*;
#(
  parameter int NUM_NA         = NUM_NA_DEF,
  parameter int ADR_WIDTH      = ADR_WIDTH_DEF,
  parameter int CRITERIO_WIDTH = CRITERIO_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  selecionar_ativo_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_NA);
  localparam int CNT_W = $clog2(NUM_NA + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NA - 1);

  sa_state_e state_q, state_d;

  logic [CNT_W-1:0]          count_q;
  logic [CRITERIO_WIDTH-1:0] crit_ref_q;
  logic [CRITERIO_WIDTH-1:0] slot_crit;
  logic [CRITERIO_WIDTH-1:0] crit_q;
  logic [ADR_WIDTH-1:0]      slot_addr;
  logic [ADR_WIDTH-1:0]      addr_q;
  logic [NUM_NA-1:0]         grant_q;
  logic                      valid_q;
  logic                      vazio_q;
  logic                      slot_valid;
  logic                      match;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          ptr;
  logic [IDX_W-1:0]          sel;

  logic idx_load, idx_inc, ptr_adv;
  logic cnt_clr, cnt_inc;
  logic take_grant, drop_grant, vazio_set;
`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
  logic min_init, min_upd, seen_q;
`else
  logic ref_load;
`endif

  selecionar_ativo_rr_idx #(.NUM_NA(NUM_NA)) u_rr_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (idx_load),
    .inc     (idx_inc),
    .ptr_adv (ptr_adv),
    .idx     (idx),
    .ptr     (ptr)
  );

  // The minimum pass walks slots in plain order; order is irrelevant for a minimum.
`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
  assign sel = (state_q == ST_MIN_SCAN) ? IDX_W'(count_q) : idx;
`else
  assign sel = idx;
`endif

  assign slot_valid = bus.na_valid_in[sel];
  assign slot_crit  = CRITERIO_WIDTH'(slot_slice(BUS_MAX_W'(bus.na_criterio_in), 32'(sel), CRITERIO_WIDTH));
  assign slot_addr  = ADR_WIDTH'(slot_slice(BUS_MAX_W'(bus.na_endereco_in), 32'(sel), ADR_WIDTH));
  assign match      = slot_valid && (slot_crit == crit_ref_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_load   = 1'b0;
    idx_inc    = 1'b0;
    ptr_adv    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    take_grant = 1'b0;
    drop_grant = 1'b0;
    vazio_set  = 1'b0;
`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
    min_init   = 1'b0;
    min_upd    = 1'b0;
`else
    ref_load   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          cnt_clr = 1'b1;
`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
          min_init = 1'b1;
          state_d  = ST_MIN_SCAN;
`else
          ref_load = 1'b1;
          idx_load = 1'b1;
          state_d  = ST_SCAN;
`endif
        end
      end
`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
      ST_MIN_SCAN: begin
        min_upd = 1'b1;
        if (count_q == CNT_LAST) begin
          cnt_clr = 1'b1;
          if (seen_q || slot_valid) begin
            idx_load = 1'b1;
            state_d  = ST_SCAN;
          end else begin
            vazio_set = 1'b1;
            state_d   = ST_IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
`endif
      ST_SCAN: begin
        if (match) begin
          take_grant = 1'b1;
          state_d    = ST_GRANT;
        end else if (count_q == CNT_LAST) begin
          vazio_set = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          idx_inc = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.ack_in) begin
          drop_grant = 1'b1;
          ptr_adv    = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      crit_ref_q <= '0;
      valid_q    <= 1'b0;
      grant_q    <= '0;
      addr_q     <= '0;
      crit_q     <= '0;
      vazio_q    <= 1'b0;
`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
      seen_q     <= 1'b0;
`endif
    end else begin
      if (cnt_clr) begin
        count_q <= '0;
      end else if (cnt_inc) begin
        count_q <= count_q + CNT_W'(1);
      end
`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
      if (min_init) begin
        crit_ref_q <= '1;
        seen_q     <= 1'b0;
      end else if (min_upd && slot_valid) begin
        seen_q <= 1'b1;
        if (slot_crit < crit_ref_q) begin
          crit_ref_q <= slot_crit;
        end
      end
`else
      if (ref_load) begin
        crit_ref_q <= bus.ca_criterio_geral_in;
      end
`endif
      if (take_grant) begin
        valid_q <= 1'b1;
        grant_q <= NUM_NA'(1) << idx;
        addr_q  <= slot_addr;
        crit_q  <= slot_crit;
      end else if (drop_grant) begin
        valid_q <= 1'b0;
        grant_q <= '0;
        addr_q  <= '0;
        crit_q  <= '0;
      end
      vazio_q <= vazio_set;
    end
  end

  assign bus.sa_valid_out    = valid_q;
  assign bus.sa_grant_out    = grant_q;
  assign bus.sa_endereco_out = addr_q;
  assign bus.sa_criterio_out = crit_q;
  assign bus.sa_vazio_out    = vazio_q;
  assign bus.sa_busy_out     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_selecionar_ativo.sv
// tb/tb_selecionar_ativo.sv - vector table plus scoreboard bench for selecionar_ativo
module tb_selecionar_ativo;
  localparam int NA = 8;
  localparam int AW = 8;
  localparam int CW = 5;
`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
  localparam int EXTRA = NA;
`else
  localparam int EXTRA = 0;
`endif
  localparam logic [NA*AW-1:0] ADDRS = {8'h30, 8'h2E, 8'h2C, 8'h2A, 8'h28, 8'h26, 8'h24, 8'h22};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  selecionar_ativo_if #(.NUM_NA(NA), .ADR_WIDTH(AW), .CRITERIO_WIDTH(CW)) bus ();

  selecionar_ativo #(.NUM_NA(NA), .ADR_WIDTH(AW), .CRITERIO_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [NA-1:0]    valid;
    logic [NA*CW-1:0] crit;
    logic [CW-1:0]    geral;
    int               ack_dly;
    bit               poke;
    bit               vazio;
    logic [NA-1:0]    grant;
    logic [AW-1:0]    addr;
    logic [CW-1:0]    critx;
    int               lat;
  } vec_t;

  typedef struct {
    bit            vazio;
    logic [NA-1:0] grant;
    logic [AW-1:0] addr;
    logic [CW-1:0] critx;
    int            lat;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic [NA-1:0] valid, logic [NA*CW-1:0] crit, logic [CW-1:0] geral,
                              int ack_dly, bit poke, bit vazio, logic [NA-1:0] grant,
                              logic [AW-1:0] addr, logic [CW-1:0] critx, int lat);
    vec_t v;
    v.valid = valid; v.crit = crit; v.geral = geral; v.ack_dly = ack_dly; v.poke = poke;
    v.vazio = vazio; v.grant = grant; v.addr = addr; v.critx = critx; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, bus.sa_valid_out, bus.sa_busy_out, bus.sa_vazio_out,
            bus.sa_grant_out, bus.sa_endereco_out, bus.sa_criterio_out};
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    bit   done;
    bus.na_valid_in          = v.valid;
    bus.na_criterio_in       = v.crit;
    bus.ca_criterio_geral_in = v.geral;
    bus.start_in             = 1'b1;
    e.vazio = v.vazio; e.grant = v.grant; e.addr = v.addr; e.critx = v.critx; e.lat = v.lat;
    sb.push_back(e);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      bus.start_in = 1'b0;
      if (bus.sa_valid_out || bus.sa_vazio_out) begin
        done = 1'b1;
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("vazio", bus.sa_vazio_out, e.vazio);
        chk("valid", bus.sa_valid_out, !e.vazio);
        if (e.vazio) begin
          @(posedge clk); #1;
          chk("vazio_pulse", outs(), 32'd0);
        end else begin
          chk("grant", bus.sa_grant_out, e.grant);
          chk("endereco", bus.sa_endereco_out, e.addr);
          chk("criterio", bus.sa_criterio_out, e.critx);
          for (int d = 0; d < v.ack_dly; d++) begin
            bus.start_in = v.poke && (d == 2);
            @(posedge clk); #1;
            bus.start_in = 1'b0;
            chk("hold", outs(), {9'd0, 3'b110, e.grant, e.addr, e.critx});
          end
          bus.ack_in = 1'b1;
          @(posedge clk); #1;
          bus.ack_in = 1'b0;
          chk("release", outs(), 32'd0);
        end
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no valid or vazio within %0d cycles, expected latency %0d", n, v.lat);
      e = sb.pop_front();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit quiet;
    bus.start_in             = 1'b0;
    bus.ack_in               = 1'b0;
    bus.na_valid_in          = '0;
    bus.na_criterio_in       = '0;
    bus.ca_criterio_geral_in = '0;
    bus.na_endereco_in       = ADDRS;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;

`ifdef SELECIONAR_ATIVO_MIN_INTERNO_EN
    tbl.push_back(mk(8'hFF, {5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd5, 5'd5, 5'd7}, 5'd0, 1, 0, 0, 8'h02, 8'h24, 5'd5, NA + 3));
    tbl.push_back(mk(8'hFF, {5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd5, 5'd5, 5'd7}, 5'd7, 0, 0, 0, 8'h04, 8'h26, 5'd5, NA + 2));
    tbl.push_back(mk(8'h00, {8{5'd1}}, 5'd1, 0, 0, 1, 8'h00, 8'h00, 5'd0, NA + 1));
    tbl.push_back(mk(8'h80, {8{5'd31}}, 5'd0, 2, 0, 0, 8'h80, 8'h30, 5'd31, NA + 6));
`else
    tbl.push_back(mk(8'h42, {8{5'd2}}, 5'd2, 1, 0, 0, 8'h02, 8'h24, 5'd2, 3));
    tbl.push_back(mk(8'h42, {8{5'd2}}, 5'd2, 0, 0, 0, 8'h40, 8'h2E, 5'd2, 6));
    tbl.push_back(mk(8'h42, {8{5'd2}}, 5'd2, 2, 0, 0, 8'h02, 8'h24, 5'd2, 4));
    tbl.push_back(mk(8'h10, {8{5'd3}}, 5'd3, 1, 0, 0, 8'h10, 8'h2A, 5'd3, 4));
    tbl.push_back(mk(8'hFF, {8{5'd9}}, 5'd4, 0, 0, 1, 8'h00, 8'h00, 5'd0, NA + 1));
    tbl.push_back(mk(8'hFF, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 5'd3, 0, 0, 0, 8'h08, 8'h28, 5'd3, 8));
    tbl.push_back(mk(8'hFF, {8{5'd31}}, 5'd31, 0, 0, 0, 8'h10, 8'h2A, 5'd31, 2));
    tbl.push_back(mk(8'h10, {8{5'd17}}, 5'd17, 0, 0, 0, 8'h10, 8'h2A, 5'd17, 9));
    tbl.push_back(mk(8'h00, {8{5'd0}}, 5'd0, 0, 0, 1, 8'h00, 8'h00, 5'd0, NA + 1));
    tbl.push_back(mk(8'h10, {8{5'd3}}, 5'd3, 10, 1, 0, 8'h10, 8'h2A, 5'd3, 9));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
    end

    quiet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.sa_busy_out || bus.sa_valid_out || bus.sa_vazio_out) quiet = 1'b0;
    end
    chk("idle_after_ack", quiet, 1'b1);

    bus.na_valid_in          = 8'h10;
    bus.na_criterio_in       = {8{5'd3}};
    bus.ca_criterio_geral_in = 5'd3;
    bus.start_in             = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      bus.start_in = 1'b0;
    end
    chk("busy_mid_scan", bus.sa_busy_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.ack_in = (c == 4);
      @(posedge clk); #1;
      bus.ack_in = 1'b0;
      if (bus.sa_busy_out || bus.sa_valid_out || bus.sa_vazio_out) quiet = 1'b0;
    end
    chk("no_grant_after_reset", quiet, 1'b1);
    run_vec(mk(8'h10, {8{5'd3}}, 5'd3, 0, 0, 0, 8'h10, 8'h2A, 5'd3, 6 + EXTRA));

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
